fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch front end for the pipelined processor, placed between the PC/instruction memory and the IF/ID register. It replaces the bare "pc + 1 every cycle" fetch with a prefetching queue of configurable depth. The queue decouples instruction-memory reads from IF/ID stalls and flushes cleanly on a taken jump, branch, call or return (redirect). It also stops fetching on halt while draining what is already fetched.

## Interface
- ADDR_W, 16, PC / instruction-memory address width
- INSTR_W, 16, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, fetch address after reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect  in  1  taken control transfer; flush and refetch from redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- halt  in  1  stop issuing new fetches (level)
- im_rd_en  out  1  instruction-memory read request this cycle
- im_addr  out  ADDR_W  read address (= fetch_pc)
- im_instr  in  INSTR_W  read data; valid the cycle after the request (synchronous IM, 1-cycle latency)
- out_valid  out  1  queue head holds a valid instruction
- out_instr  out  INSTR_W  head instruction
- out_pc_plus1  out  ADDR_W  head instruction address + 1 (mod 2^ADDR_W)
- out_ready  in  1  consumer (IF/ID write enable) accepts head this cycle
- count  out  clog2(DEPTH)+1  occupied entries
- fetch_pc  out  ADDR_W  next address to be issued

## Operation
- State: fetch_pc; circular buffer of DEPTH {instr, pc_plus1}; rd_ptr, wr_ptr (mod DEPTH); count; inflight bit + inflight_pc.
- Issue: im_rd_en = !rst && !halt && !redirect && (count + inflight − pop) < DEPTH. On issue, fetch_pc ← fetch_pc + 1 (wraps 2^ADDR_W−1 → 0); inflight ← 1; inflight_pc ← fetch_pc. Without issue, inflight ← 0.
- Push: when inflight = 1 and no redirect this cycle, write {im_instr, inflight_pc + 1} at wr_ptr; wr_ptr++.
- Pop: pop = out_valid && out_ready && !redirect; rd_ptr++.
- count: +1 on push only, −1 on pop only, unchanged on push + pop.
- Redirect (highest priority after rst): count ← 0, rd_ptr ← wr_ptr, inflight ← 0 (in-flight response discarded), fetch_pc ← redirect_pc; no issue, push or pop that cycle.
- Halt: issuing stops; an in-flight response still pushes; the queue keeps draining via out_ready. Deasserting halt resumes at fetch_pc.
- out_valid = (count ≠ 0); out_instr / out_pc_plus1 come from rd_ptr (combinational read of registered storage).
- Full: an issue is never made unless a slot is guaranteed, so a push never overflows; a pop never happens while empty.

## Timing
- Reset values: fetch_pc = RESET_PC, count = 0, pointers = 0, inflight = 0, out_valid = 0, im_rd_en = 0 while rst is high.
- rst overrides redirect, halt and out_ready in the same cycle.
- Fetch latency: issue in cycle N → im_instr sampled and pushed at the end of N+1 → out_valid in N+2.
- After rst deasserts in cycle C0: im_addr = RESET_PC with im_rd_en = 1 in C0; out_valid = 1 with out_pc_plus1 = RESET_PC + 1 in C2.
- Redirect in cycle R: out_valid = 0 in R+1; redirect_pc issued in R+1; its instruction at the head in R+3.
- Steady state with out_ready held at 1: one instruction per cycle; queue occupancy is 1.
- Back-to-back redirects: each cancels the previous one; only the last redirect_pc is fetched.
- Reset mid-operation: everything returns to reset values on the next edge; no stale push follows.

## Test plan
- Reset then free run, out_ready = 1, IM[i] = 0xA000 + i, RESET_PC = 0 → out_valid rises in C2; heads are 0xA000, 0xA001, … on consecutive cycles, out_pc_plus1 = 1, 2, …
- Hold out_ready = 0 from C0 → count reaches 4 (DEPTH = 4); im_rd_en drops once count + inflight = 4; release → 4 heads in order, then streaming resumes with no gap beyond 2 cycles.
- Queue holds 3 entries with a fetch in flight; assert redirect, redirect_pc = 0x0040 → count = 0 and out_valid = 0 next cycle; the in-flight word is never output; the next head is IM[0x0040], out_pc_plus1 = 0x0041, in R+3.
- Redirect asserted while out_valid && out_ready → no pop counted; a redirect on two consecutive cycles (0x10 then 0x20) → the first head is IM[0x20].
- Halt with 2 entries and one in flight, out_ready = 1 → exactly 3 instructions are delivered, then out_valid = 0 and im_rd_en stays 0; deassert halt → fetch resumes at the following address.
- fetch_pc = 0xFFFF → issues 0xFFFF then 0x0000; out_pc_plus1 for 0xFFFF is 0x0000. Assert rst mid-stream → count = 0, fetch_pc = RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory read port plus the head-of-queue
// handshake towards the IF/ID register.
interface fetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               im_rd_en;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_instr;

  // Head handshake: out_valid says the head entry is present and stable;
  // it is consumed on a rising edge where out_valid && out_ready are both high.
  // out_valid never depends on out_ready; out_ready may depend on out_valid.
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc_plus1;
  logic               out_ready;

  modport master (
    output im_rd_en, im_addr, out_valid, out_instr, out_pc_plus1,
    input  im_instr, out_ready
  );

  modport slave (
    input  im_rd_en, im_addr, out_valid, out_instr, out_pc_plus1,
    output im_instr, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch queue: issues reads to a 1-cycle synchronous
// instruction memory and buffers {instr, pc+1} entries ahead of IF/ID.
module fetch_queue #(
  parameter int               ADDR_W   = 16,
  parameter int               INSTR_W  = 16,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     halt,
  fetch_queue_if.master            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ADDR_W-1:0]        fetch_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc1_mem   [DEPTH];

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occupancy;

  // A read is only issued when a slot is guaranteed for its response,
  // counting the entry still in flight and the one leaving this cycle.
  always_comb begin
    pop       = (count != '0) && bus.out_ready && !redirect;
    push      = inflight && !redirect;
    occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    issue     = !rst && !halt && !redirect && (occupancy < OCC_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      // Flush: the queue empties and any response in flight is dropped.
      fetch_pc <= redirect_pc;
      count    <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem[wr_ptr] <= bus.im_instr;
      pc1_mem[wr_ptr]   <= inflight_pc + ADDR_W'(1);
    end
  end

  assign bus.im_rd_en     = issue;
  assign bus.im_addr      = fetch_pc;
  assign bus.out_valid    = (count != '0);
  assign bus.out_instr    = instr_mem[rd_ptr];
  assign bus.out_pc_plus1 = pc1_mem[rd_ptr];
endmodule
